// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: commit-record FIFO with halt detection, R0 suppression,
// sticky overflow and drain-after-halt. Define COMMIT_PERF_EN for perf counters.
module commit_trace_buffer #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] HALT_INST = 32'h8000_0000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       global_en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_pc,
   input  logic [31:0]                in_inst,
   input  logic                       in_reg_we,
   input  logic [4:0]                 in_reg_wa,
   input  logic [31:0]                in_reg_wd,
   input  logic                       in_dmem_we,
   input  logic [31:0]                in_dmem_wa,
   input  logic [31:0]                in_dmem_wd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                commit_pc,
   output logic [31:0]                commit_inst,
   output logic                       commit_halt,
   output logic                       commit_reg_we,
   output logic                       commit_dmem_we,
   output logic [4:0]                 commit_reg_wa,
   output logic [31:0]                commit_reg_wd,
   output logic [31:0]                commit_dmem_wa,
   output logic [31:0]                commit_dmem_wd,
   output logic                       halted,
   output logic                       overflow,
   output logic [$clog2(DEPTH):0]     count,
   output logic [31:0]                perf_cycles,
   output logic [31:0]                perf_insts,
   output logic [31:0]                perf_stalls
);
   localparam int AW = $clog2(DEPTH);
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        halt;
      logic        reg_we;
      logic [4:0]  reg_wa;
      logic [31:0] reg_wd;
      logic        dmem_we;
      logic [31:0] dmem_wa;
      logic [31:0] dmem_wd;
   } rec_t;
   rec_t          r_mem [DEPTH];
   logic [AW-1:0] r_rd, r_wr;
   logic [AW:0]   r_count;
   logic          r_halted, r_overflow;
   logic          w_full, w_push, w_pop;
   rec_t          w_in, w_out;
   assign w_full    = r_count == (AW+1)'(DEPTH);
   assign in_ready  = !w_full && !r_halted;
   assign out_valid = r_count != '0;
   assign w_push    = global_en && in_valid && in_ready;
   assign w_pop     = global_en && out_valid && out_ready;
   assign w_in      = '{pc: in_pc, inst: in_inst, halt: in_inst == HALT_INST,
                        reg_we: in_reg_we && (in_reg_wa != 5'd0), reg_wa: in_reg_wa,
                        reg_wd: in_reg_wd, dmem_we: in_dmem_we, dmem_wa: in_dmem_wa,
                        dmem_wd: in_dmem_wd};
   assign w_out     = out_valid ? r_mem[r_rd] : '0;
   assign commit_pc      = w_out.pc;
   assign commit_inst    = w_out.inst;
   assign commit_halt    = w_out.halt;
   assign commit_reg_we  = w_out.reg_we;
   assign commit_reg_wa  = w_out.reg_wa;
   assign commit_reg_wd  = w_out.reg_wd;
   assign commit_dmem_we = w_out.dmem_we;
   assign commit_dmem_wa = w_out.dmem_wa;
   assign commit_dmem_wd = w_out.dmem_wd;
   assign halted   = r_halted;
   assign overflow = r_overflow;
   assign count    = r_count;
   // record storage: written only on an accepted push, never reset
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_in;
   end
   // pointers, occupancy, sticky halt and overflow; frozen when global_en=0
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
         r_halted   <= 1'b0;
         r_overflow <= 1'b0;
      end else if (global_en) begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
         if (w_push && w_in.halt) r_halted <= 1'b1;
         if (in_valid && w_full && !r_halted) r_overflow <= 1'b1;
      end
   end
`ifdef COMMIT_PERF_EN
   logic [31:0] r_cycles, r_insts, r_stalls;
   // perf counters advance only while running and not halted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycles <= '0;
         r_insts  <= '0;
         r_stalls <= '0;
      end else if (global_en && !r_halted) begin
         r_cycles <= r_cycles + 32'd1;
         if (w_push) r_insts <= r_insts + 32'd1;
         if (in_valid && !in_ready) r_stalls <= r_stalls + 32'd1;
      end
   end
   assign perf_cycles = r_cycles;
   assign perf_insts  = r_insts;
   assign perf_stalls = r_stalls;
`else
   assign perf_cycles = '0;
   assign perf_insts  = '0;
   assign perf_stalls = '0;
`endif
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Parametrised commit-record FIFO between the LA32R core's retire point and the debug/difftest commit interface.
- The core pushes one record per retired instruction. The simulation harness drains records with a valid/ready handshake, so the core never has to hold its commit registers while the harness is busy.
- Adds HALT detection with a configurable encoding, suppression of writes to R0, sticky overflow reporting, and drain-after-halt.

Parameters:
- DEPTH, 8, number of record slots; power of two, >= 2.
- HALT_INST, 32'h8000_0000, instruction encoding that marks the halt record.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- global_en  input  1  core run enable; when 0, the block freezes (no push, no pop, no counter updates)
- in_valid  input  1  core presents a retired instruction
- in_ready  output  1  record accepted this cycle when in_valid&&in_ready&&global_en
- in_pc, in_inst  input  32 each  retired PC and instruction
- in_reg_we  input  1; in_reg_wa  input  5; in_reg_wd  input  32  regfile write info
- in_dmem_we  input  1; in_dmem_wa  input  32; in_dmem_wd  input  32  store info
- out_valid  output  1  head record valid
- out_ready  input  1  harness consumes head
- commit_pc, commit_inst  output  32 each
- commit_halt, commit_reg_we, commit_dmem_we  output  1 each
- commit_reg_wa  output  5
- commit_reg_wd, commit_dmem_wa, commit_dmem_wd  output  32 each
- halted  output  1  halt record accepted (sticky)
- overflow  output  1  sticky; a record was offered while full
- count  output  $clog2(DEPTH)+1  occupancy
- perf_cycles, perf_insts, perf_stalls  output  32 each  see Optional Feature

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset clears read pointer, write pointer, count, halted, overflow and all perf counters. It also sets out_valid=0.
- Reset mid-operation discards all buffered records. The block accepts records again in the cycle after rst deasserts.
- in_ready = !full && !halted. in_ready is combinational and independent of in_valid and out_ready.
- A push while full is never allowed, even with a simultaneous pop.
- Push, at the clk edge when global_en && in_valid && in_ready:
  - write the record at the write pointer;
  - record.halt = (in_inst == HALT_INST);
  - record.reg_we = in_reg_we && (in_reg_wa != 0), so R0 writes are suppressed;
  - all other fields are stored verbatim.
- Pop, at the clk edge when global_en && out_valid && out_ready: advance the read pointer.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is updated by +1, -1, or 0 when push and pop happen together.
- Latency: a record pushed at edge N appears with out_valid=1 after edge N. There is no bypass; an empty buffer with a same-cycle push still shows out_valid=0 in that cycle.
- Outputs:
  - out_valid = (count != 0).
  - When out_valid=1, the commit_* signals reflect the storage slot at the read pointer. They stay stable while out_valid && !out_ready.
  - When out_valid=0, all commit_* outputs are 0.
- Halt:
  - Accepting a record with halt=1 sets halted on the same edge.
  - Further pushes are blocked; remaining records, including the halt record, keep draining normally.
  - halted clears only on rst.
- Overflow:
  - Set on the edge where global_en && in_valid && full && !halted.
  - The offered record is dropped.
  - in_valid while halted does not set overflow.
- global_en=0 freezes the block: no push, no pop, no overflow update, no counter update. Outputs keep their current values.

Optional Feature:
- Macro: COMMIT_PERF_EN.
- Defined:
  - perf_cycles increments on every global_en cycle while !halted.
  - perf_insts increments on every accepted push.
  - perf_stalls increments on every global_en cycle with in_valid && !in_ready && !halted.
  - All three counters wrap at 2^32 and reset to 0.
- Undefined: the three perf ports exist but are driven constant 0, with no counter flops.

Test Plan:
- Basic ordering: DEPTH=8, out_ready=1, push pc=0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles. Required: out_valid rises one cycle after the first push, records pop in the same order, count never exceeds 1.
- Backpressure and fill: out_ready=0, push 8 records. Required: count=8, in_ready=0; a 9th in_valid sets overflow=1 and that record is never output. Then out_ready=1: exactly 8 records drain, the pointer wraps, count=0.
- R0 suppression: push a record with inst=0x02800400, reg_we=1, reg_wa=0, wd=5. Required: commit_reg_we=0, commit_reg_wd=5.
- Halt: push A, then inst=0x80000000, then B. Required: halted=1 after the second push, B is not accepted (in_ready=0, overflow stays 0). The drain gives A, then the halt record with commit_halt=1.
- Freeze and reset: with global_en=0 and in_valid=out_ready=1 for 5 cycles, count is unchanged. Asserting rst with count=4 gives count=0, out_valid=0 and halted=0 on the next edge.
- With COMMIT_PERF_EN defined: 10 enabled cycles with 6 pushes and 2 full-stall cycles, no halt. Required: perf_cycles=10, perf_insts=6, perf_stalls=2.
